pfb_acc_seed: RTL and testbench

Input-side counterpart of the PFB output rounding stage. It accepts 16-bit signed samples on a valid/ready stream and expands each one into a 48-bit accumulator word for the head of the PFB MAC cascade. The sample sits in bits [39:24], so the downstream rounding stage recovers it unchanged after the 24-bit round/shift. The block also tracks channel position within each frame of NUM_CHANS samples and flags framing errors.

---
 rtl/pfb_consts.sv | 20 ++
 rtl/pfb_skid.sv | 51 +++++
 rtl/pfb_acc_seed.sv | 81 ++++++++
 tb/tb_pfb_acc_seed.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pfb_consts.sv
// Shared PFB accumulator alignment constants.
// Seed formatting and the downstream rounding stage both import these.
package pfb_consts;

  localparam int PFB_ACC_WIDTH  = 48;
  localparam int PFB_SAMP_WIDTH = 16;
  localparam int PFB_RND_SHIFT  = 24;
  localparam int PFB_EXT_WIDTH  =
    PFB_ACC_WIDTH - PFB_RND_SHIFT - PFB_SAMP_WIDTH;

  // Sample lands on [39:24] so the 24-bit round/shift returns it intact.
  function automatic logic [PFB_ACC_WIDTH-1:0] pfb_seed(
    input logic [PFB_SAMP_WIDTH-1:0] s
  );
    return {{PFB_EXT_WIDTH{s[PFB_SAMP_WIDTH-1]}},
            s,
            {PFB_RND_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/pfb_skid.sv
// Generic 2-entry register slice: output register plus skid register.
// s_ready is registered and equals !skid_full.
module pfb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         sync_reset,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);

  logic         skid_full;
  logic [W-1:0] skid_data;
  logic         acc;

  assign acc = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      s_ready   <= 1'b0;
    end else if (skid_full) begin
      if (m_ready) begin
        m_data    <= skid_data;
        skid_full <= 1'b0;
        s_ready   <= 1'b1;
      end
    end else if (!m_valid || m_ready) begin
      m_valid <= acc;
      if (acc) begin
        m_data <= s_data;
      end
      s_ready <= 1'b1;
    end else if (acc) begin
      // Output held: park the new beat and stop accepting.
      skid_data <= s_data;
      skid_full <= 1'b1;
      s_ready   <= 1'b0;
    end else begin
      s_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/pfb_acc_seed.sv
// PFB accumulator seed: formats samples into 48-bit MAC words,
// tracks channel position per frame and flags framing errors.
module pfb_acc_seed
  import pfb_consts::*;
#(
  parameter int NUM_CHANS  = 64,
  parameter int CHAN_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     s_valid,
  input  logic [15:0]              s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [47:0]              m_data,
  output logic [CHAN_WIDTH-1:0]    m_chan,
  output logic                     m_last,
  output logic                     m_err,
  input  logic                     m_ready
);

  typedef struct packed {
    logic [PFB_ACC_WIDTH-1:0] data;
    logic [CHAN_WIDTH-1:0]    chan;
    logic                     last;
    logic                     err;
  } beat_t;

  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN =
    CHAN_WIDTH'(NUM_CHANS - 1);

  logic [CHAN_WIDTH-1:0] chan_cnt;
  logic                  at_last;
  logic                  acc;
  beat_t                 in_beat;
  beat_t                 out_beat;

  assign at_last = (chan_cnt == LAST_CHAN);
  assign acc     = s_valid && s_ready;

  always_comb begin
    in_beat      = '0;
    in_beat.data = pfb_seed(s_data);
    in_beat.chan = chan_cnt;
    in_beat.last = at_last;
    in_beat.err  = s_last ^ at_last;
  end

  // Early s_last resyncs; a missing s_last still wraps at frame end.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      chan_cnt <= '0;
    end else if (acc) begin
      if (at_last || s_last) begin
        chan_cnt <= '0;
      end else begin
        chan_cnt <= chan_cnt + CHAN_WIDTH'(1);
      end
    end
  end

  pfb_skid #(
    .W($bits(beat_t))
  ) u_skid (
    .clk        (clk),
    .sync_reset (sync_reset),
    .s_valid    (s_valid),
    .s_data     (in_beat),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (out_beat),
    .m_ready    (m_ready)
  );

  assign m_data = out_beat.data;
  assign m_chan = out_beat.chan;
  assign m_last = out_beat.last;
  assign m_err  = out_beat.err;

endmodule

// File: tb/tb_pfb_acc_seed.sv
// Directed bench for pfb_acc_seed with NUM_CHANS=4.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_pfb_acc_seed;

  logic        clk;
  logic        sync_reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [47:0] m_data;
  logic [9:0]  m_chan;
  logic        m_last;
  logic        m_err;
  logic        m_ready;

  int checks = 0;
  int errors = 0;

  pfb_acc_seed #(
    .NUM_CHANS  (4),
    .CHAN_WIDTH (10)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .m_err      (m_err),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    step();
    sync_reset = 1'b0;
    step();
  endtask

  logic [15:0] fmt_in  [3];
  logic [47:0] fmt_exp [3];
  logic        fe_last [7];
  int          fe_chan [7];
  logic        fe_err  [7];
  logic        fe_mlst [7];
  int          sent, rcvd, occ, acc, xfer;

  initial begin
    fmt_in  = '{16'h7FFF, 16'h8000, 16'h0001};
    fmt_exp = '{48'h007FFF000000, 48'hFF8000000000, 48'h000001000000};
    fe_last = '{0, 1, 0, 0, 0, 0, 0};
    fe_chan = '{0, 1, 0, 1, 2, 3, 0};
    fe_err  = '{0, 1, 0, 0, 0, 1, 0};
    fe_mlst = '{0, 0, 0, 0, 0, 1, 0};

    sync_reset = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_err", m_err, 0);
    sync_reset = 1'b0;
    step();
    chk("rst_rel_s_ready", s_ready, 1);

    // Formatting, one cycle latency.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = fmt_in[i];
      step();
      chk("fmt_valid", m_valid, 1);
      chk("fmt_data", m_data, fmt_exp[i]);
      chk("fmt_chan", m_chan, 64'(i));
    end
    s_valid = 1'b0;
    step();
    chk("fmt_idle", m_valid, 0);

    // Clean framing over two frames.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i + 16'h10);
      s_last  = (i % 4 == 3);
      step();
      chk("frm_chan", m_chan, 64'(i % 4));
      chk("frm_last", m_last, 64'(i % 4 == 3));
      chk("frm_err", m_err, 0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();

    // Early s_last, then missing s_last.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      s_last  = fe_last[i];
      step();
      chk("fe_chan", m_chan, 64'(fe_chan[i]));
      chk("fe_err", m_err, 64'(fe_err[i]));
      chk("fe_last", m_last, 64'(fe_mlst[i]));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();

    // Random backpressure against an occupancy model.
    do_reset();
    sent    = 0;
    rcvd    = 0;
    occ     = 0;
    s_valid = 1'b1;
    s_data  = 16'd0;
    s_last  = 1'b0;
    m_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
      acc  = int'(s_valid && s_ready);
      xfer = int'(m_valid && m_ready);
      if (xfer != 0) begin
        chk("bp_data", m_data, {8'h00, 16'(rcvd), 24'h0});
        chk("bp_chan", m_chan, 64'(rcvd % 4));
        chk("bp_err", m_err, 0);
      end
      step();
      sent += acc;
      rcvd += xfer;
      occ  += acc - xfer;
      chk("bp_s_ready", s_ready, 64'(occ < 2));
      chk("bp_m_valid", m_valid, 64'(occ > 0));
      s_valid = (sent < 100);
      s_data  = 16'(sent);
      s_last  = (sent % 4 == 3);
      m_ready = 1'($urandom_range(0, 1));
    end
    chk("bp_count", 64'(rcvd), 100);
    s_valid = 1'b0;
    s_last  = 1'b0;

    // Mid-stream reset with the skid full.
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h1111;
    step();
    s_data = 16'h2222;
    step();
    chk("mr_full_s_ready", s_ready, 0);
    s_data     = 16'h3333;
    sync_reset = 1'b1;
    step();
    chk("mr_m_valid", m_valid, 0);
    chk("mr_s_ready", s_ready, 0);
    chk("mr_m_data", m_data, 0);
    sync_reset = 1'b0;
    step();
    chk("mr_rel_s_ready", s_ready, 1);
    chk("mr_rel_m_valid", m_valid, 0);
    m_ready = 1'b1;
    step();
    chk("mr_new_valid", m_valid, 1);
    chk("mr_new_data", m_data, 48'h003333000000);
    chk("mr_new_chan", m_chan, 0);
    s_valid = 1'b0;
    step();
    chk("mr_no_old", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
